// File: rtl/evt_pkg.sv
// evt_pkg: shared register map and bus widths for the event status block.
//   BUS_ADDR_W / BUS_DATA_W : word address and data widths of the register bus
//   ADDR_*                  : word addresses of the register file
package evt_pkg;

  localparam int BUS_ADDR_W = 5;
  localparam int BUS_DATA_W = 32;

  localparam logic [BUS_ADDR_W-1:0] ADDR_STATUS   = 5'd0;
  localparam logic [BUS_ADDR_W-1:0] ADDR_MASK     = 5'd1;
  localparam logic [BUS_ADDR_W-1:0] ADDR_OVERFLOW = 5'd2;
  localparam logic [BUS_ADDR_W-1:0] ADDR_PENDING  = 5'd3;
  localparam logic [BUS_ADDR_W-1:0] ADDR_CNT_BASE = 5'd16;

  // Word address of the counter belonging to event source idx.
  function automatic logic [BUS_ADDR_W-1:0] cnt_addr(input int idx);
    return ADDR_CNT_BASE + BUS_ADDR_W'(idx);
  endfunction

endpackage

// File: rtl/evt_sat_counter.sv
// evt_sat_counter: saturating event counter with clear.
//   clk     : clock, rising edge
//   reset_n : synchronous active-low reset, clears the count
//   inc     : count one event this cycle
//   clr     : clear the count this cycle; a coinciding inc leaves the count at 1
//   cnt     : current count, sticks at all-ones
module evt_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? CNT_W'(1) : '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/event_status_reader.sv
// event_status_reader: sticky per-source event status with mask, overflow
// tracking, level interrupt and a registered read bus.
//   clk, reset_n       : clock (rising edge), synchronous active-low reset
//   evt                : one-cycle event strobes, one per source
//   chipselect, read,
//   write, address,
//   writedata          : register bus request (read wins over write)
//   readdata,
//   readdatavalid      : read response, one cycle after an accepted read
//   irq                : registered |(STATUS & MASK)
// Build option: define EVT_COUNT_EN to add per-source saturating counters at
// word addresses 16+i (clear-on-read). Without it those addresses read 0.
module event_status_reader
  import evt_pkg::*;
#(
  parameter int NUM_EVT = 8,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_EVT-1:0]    evt,
  input  logic                  chipselect,
  input  logic                  read,
  input  logic                  write,
  input  logic [BUS_ADDR_W-1:0] address,
  input  logic [BUS_DATA_W-1:0] writedata,
  output logic [BUS_DATA_W-1:0] readdata,
  output logic                  readdatavalid,
  output logic                  irq
);

  logic [NUM_EVT-1:0]    status;
  logic [NUM_EVT-1:0]    overflow;
  logic [NUM_EVT-1:0]    mask;
  logic [NUM_EVT-1:0]    status_clr;
  logic [NUM_EVT-1:0]    overflow_clr;
  logic                  rd_acc;
  logic                  wr_acc;
  logic [BUS_DATA_W-1:0] rd_mux;
  logic [BUS_DATA_W-1:0] rdata_p1;
  logic                  vld_p1;
  logic                  irq_p1;
  logic                  unused_wdata;

  assign rd_acc       = chipselect & read;
  assign wr_acc       = chipselect & write & ~read;
  assign unused_wdata = ^writedata;

  // A read of STATUS/OVERFLOW clears every bit; a write clears the ones set.
  always_comb begin
    status_clr   = '0;
    overflow_clr = '0;
    if (rd_acc) begin
      if (address == ADDR_STATUS)   status_clr   = '1;
      if (address == ADDR_OVERFLOW) overflow_clr = '1;
    end else if (wr_acc) begin
      if (address == ADDR_STATUS)   status_clr   = writedata[NUM_EVT-1:0];
      if (address == ADDR_OVERFLOW) overflow_clr = writedata[NUM_EVT-1:0];
    end
  end

  // Events are OR-ed in after the clear so a coinciding event is never lost.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      status   <= '0;
      overflow <= '0;
      mask     <= '0;
    end else begin
      status   <= (status & ~status_clr) | evt;
      overflow <= (overflow & ~overflow_clr) | (evt & status);
      if (wr_acc && (address == ADDR_MASK)) begin
        mask <= writedata[NUM_EVT-1:0];
      end
    end
  end

`ifdef EVT_COUNT_EN
  logic [CNT_W-1:0] cnt [NUM_EVT];

  for (genvar i = 0; i < NUM_EVT; i++) begin : g_cnt
    logic cnt_clr;
    assign cnt_clr = rd_acc && (address == cnt_addr(i));
    evt_sat_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (evt[i]),
      .clr     (cnt_clr),
      .cnt     (cnt[i])
    );
  end
`else
  // CNT_W only sizes the counters, which are absent in this build.
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_STATUS:   rd_mux[NUM_EVT-1:0] = status;
      ADDR_MASK:     rd_mux[NUM_EVT-1:0] = mask;
      ADDR_OVERFLOW: rd_mux[NUM_EVT-1:0] = overflow;
      ADDR_PENDING:  rd_mux[NUM_EVT-1:0] = status & mask;
      default: begin
`ifdef EVT_COUNT_EN
        for (int i = 0; i < NUM_EVT; i++) begin
          if (address == cnt_addr(i)) rd_mux[CNT_W-1:0] = cnt[i];
        end
`endif
      end
    endcase
  end

  // ---- stage p1: registered read response and interrupt ----
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdata_p1 <= '0;
      vld_p1   <= 1'b0;
      irq_p1   <= 1'b0;
    end else begin
      vld_p1 <= rd_acc;
      if (rd_acc) rdata_p1 <= rd_mux;
      irq_p1 <= |(status & mask);
    end
  end

  assign readdata      = rdata_p1;
  assign readdatavalid = vld_p1;
  assign irq           = irq_p1;

endmodule

// File: doc/event_status_reader.md
EVENT_STATUS_READER -- requirements
Module: event_status_reader

Interface
REQ-001 SHALL have parameter NUM_EVT, default 8, number of event sources (legal 1..16).
REQ-002 SHALL have parameter CNT_W, default 16, per-event counter width (legal 4..32).
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port evt, input, NUM_EVT, per-source one-cycle event strobes.
REQ-006 SHALL have port chipselect, input, 1, bus access qualifier.
REQ-007 SHALL have port read, input, 1, read strobe, valid with chipselect.
REQ-008 SHALL have port write, input, 1, write strobe, valid with chipselect.
REQ-009 SHALL have port address, input, 5, word address.
REQ-010 SHALL have port writedata, input, 32, write data.
REQ-011 SHALL have port readdata, output, 32, registered read data.
REQ-012 SHALL have port readdatavalid, output, 1, qualifies readdata.
REQ-013 SHALL have port irq, output, 1, level interrupt request.

Function
REQ-014 SHALL keep sticky STATUS[i], set when evt[i]=1, cleared only by bus access.
REQ-015 SHALL keep sticky OVERFLOW[i], set when evt[i]=1 while STATUS[i] already 1.
REQ-016 SHALL map: 0 STATUS (clear-on-read, W1C), 1 MASK (RW, reset 0), 2 OVERFLOW (clear-on-read, W1C), 3 PENDING = STATUS&MASK (RO, no side effect); other addresses read 0, writes ignored.
REQ-017 SHALL return readdata and assert readdatavalid exactly one cycle after an accepted read (chipselect&read); readdatavalid low otherwise.
REQ-018 SHALL return the pre-clear register value on a clear-on-read; bits above NUM_EVT read 0.
REQ-019 SHALL give set priority: evt[i] in the same cycle as a read-clear or W1C of bit i leaves bit i set.
REQ-020 SHALL ignore write when read is also asserted in the same cycle (read wins).
REQ-021 SHALL drive irq registered: irq = |(STATUS & MASK) of the previous cycle (one-cycle latency).
REQ-022 SHALL ignore read/write when chipselect=0 with no side effects.

Reset
REQ-023 SHALL, on reset_n=0 at a clock edge, clear STATUS, OVERFLOW, MASK, counters, readdata, readdatavalid, irq to 0.
REQ-024 SHALL discard an access in flight: a read accepted in the reset cycle produces no readdatavalid.
REQ-025 SHALL ignore evt while reset_n=0.

Configuration
REQ-026 SHALL, with EVT_COUNT_EN defined, provide per-event CNT_W-bit counters at addresses 16+i, incremented per evt[i], saturating at all-ones, cleared on read, read value zero-extended.
REQ-027 SHALL, when a counter clear-on-read coincides with evt[i], load the counter with 1.
REQ-028 SHALL, without EVT_COUNT_EN, instantiate no counters; addresses 16..31 read 0.

Structure
REQ-029 SHALL place register address constants (ADDR_STATUS, ADDR_MASK, ADDR_OVERFLOW, ADDR_PENDING, ADDR_CNT_BASE) and bus widths in shared package evt_pkg.
REQ-030 SHALL implement counters in one sub-module evt_sat_counter (increment, clear, saturate), generated per event.

Verification
REQ-031 SHALL cover: evt[3] pulse, read addr 0 -> readdata 0x08 next cycle, second read -> 0x00.
REQ-032 SHALL cover: MASK=0x04, evt[2] pulse -> irq high 2 cycles after pulse; W1C 0x04 to addr 0 -> irq low one cycle later.
REQ-033 SHALL cover: evt[1] twice, no read -> OVERFLOW read 0x02, STATUS read 0x02.
REQ-034 SHALL cover: evt[5] same cycle as read addr 0 with STATUS=0x20 -> readdata 0x20, next read 0x20.
REQ-035 SHALL cover (EVT_COUNT_EN, CNT_W=4): 20 pulses on evt[0] -> addr 16 reads 0xF, then 0x0.
REQ-036 SHALL cover: read accepted then reset_n=0 next cycle -> readdatavalid 0, all registers read 0 after reset.
